// File: rtl/axi_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axi_mem_arbiter_pkg
//   Shared types and constants for the instruction/data AXI4-Lite arbiter.
//   - state_t : bus FSM states
//   - owner_t : which core port owns the current transaction
//   - AXI response code and protection encodings used on AR/AW
// ---------------------------------------------------------------------------
package axi_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } owner_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [2:0] PROT_INSTR    = 3'b100;
    localparam logic [2:0] PROT_DATA     = 3'b000;

    // Any response other than OKAY (SLVERR, DECERR, EXOKAY) is reported
    // to the core as an error; there is no exclusive access on this path.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_mem_arbiter_if
//   AXI4-Lite bus bundle (AR, R, AW, W, B channels).
//   modport master : driven by the arbiter towards the interconnect
//   modport slave  : driven by the memory / interconnect side
// ---------------------------------------------------------------------------
interface axi_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // AR channel
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    // R channel
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;
    // AW channel
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    // W channel
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    // B channel
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready,
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready,
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_mem_arbiter_rr_arbiter_2.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
//   Two-requester round-robin arbiter with a registered "last granted"
//   pointer. Grants are combinational and only issued while enable is high.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     enable        : arbitration window (arbiter may grant this cycle)
//     req[1:0]      : requests, bit 0 = instruction port, bit 1 = data port
//     gnt[1:0]      : one-hot grant (all zero when no req or not enabled)
//     last          : owner of the most recent grant (resets to DATA so the
//                     first tie goes to the instruction port)
// ---------------------------------------------------------------------------
module rr_arbiter_2
    import axi_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output owner_t     last
);

    owner_t last_reg;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // Tie: whoever did not win last time goes now.
                2'b11:   gnt = (last_reg == DATA) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg <= DATA;
        end else if (gnt != 2'b00) begin
            last_reg <= gnt[1] ? DATA : INSTR;
        end
    end

    assign last = last_reg;

endmodule

// File: rtl/axi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// axi_mem_arbiter
//   Shares one AXI4-Lite master between the core's instruction-fetch port
//   (read only) and data port (load/store). Both core ports use the
//   req/gnt/rvalid protocol; one AXI transaction is outstanding at a time.
//   Ports:
//     clk, rst                        : clock, synchronous active-high reset
//     instr_req_i, instr_addr_i       : fetch request / address
//     instr_gnt_o                     : combinational grant (IDLE only)
//     instr_rvalid_o, instr_err_o     : response pulse and error flag
//     instr_rdata_o                   : last fetched word (held)
//     data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i
//                                     : load/store request and payload
//     data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o
//                                     : grant, response pulse, error, load data
//     m_axi                           : AXI4-Lite master bundle
// ---------------------------------------------------------------------------
module axi_mem_arbiter
    import axi_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic                    instr_err_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,

    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic                    data_err_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,

    axi_mem_arbiter_if.master       m_axi
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    state_t                state_reg;
    state_t                state_next;

    // Transaction latches, captured on the grant edge.
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [STRB_WIDTH-1:0] be_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;

    // Write-channel progress: AW and W complete independently.
    logic                  aw_done_reg;
    logic                  w_done_reg;

    logic [DATA_WIDTH-1:0] instr_rdata_reg;
    logic [DATA_WIDTH-1:0] data_rdata_reg;
    logic                  instr_rvalid_reg;
    logic                  data_rvalid_reg;
    logic                  instr_err_reg;
    logic                  data_err_reg;

    logic [1:0]            gnt;
    owner_t                owner;

    logic                  arvalid;
    logic                  rready;
    logic                  awvalid;
    logic                  wvalid;
    logic                  bready;
    logic                  aw_hs;
    logic                  w_hs;

    // -----------------------------------------------------------------------
    // Arbitration. The round-robin pointer only moves on a grant, and grants
    // only happen in IDLE, so after the grant edge it names the owner of the
    // transaction in flight for its whole duration; it doubles as the owner
    // latch.
    // -----------------------------------------------------------------------
    rr_arbiter_2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .enable (state_reg == IDLE),
        .req    ({data_req_i, instr_req_i}),
        .gnt    (gnt),
        .last   (owner)
    );

    assign instr_gnt_o = gnt[0];
    assign data_gnt_o  = gnt[1];

    // -----------------------------------------------------------------------
    // Channel handshakes and valid/ready drivers
    // -----------------------------------------------------------------------
    always_comb begin
        arvalid = 1'b0;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (state_reg)
            RD_ADDR: arvalid = 1'b1;
            RD_DATA: rready  = 1'b1;
            WR_ADDR: begin
                // Each valid drops after its own handshake and is never
                // re-presented for the same transaction.
                awvalid = !aw_done_reg;
                wvalid  = !w_done_reg;
            end
            WR_RESP: bready  = 1'b1;
            default: ;
        endcase
    end

    assign aw_hs = awvalid && m_axi.awready;
    assign w_hs  = wvalid  && m_axi.wready;

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (gnt[0]) begin
                    state_next = RD_ADDR;
                end else if (gnt[1]) begin
                    state_next = data_we_i ? WR_ADDR : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (m_axi.arready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axi.rvalid) begin
                    state_next = IDLE;
                end
            end
            WR_ADDR: begin
                if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi.bvalid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State, latches and response registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            addr_reg         <= '0;
            be_reg           <= '0;
            wdata_reg        <= '0;
            aw_done_reg      <= 1'b0;
            w_done_reg       <= 1'b0;
            instr_rdata_reg  <= '0;
            data_rdata_reg   <= '0;
            instr_rvalid_reg <= 1'b0;
            data_rvalid_reg  <= 1'b0;
            instr_err_reg    <= 1'b0;
            data_err_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;

            // Response flags are single-cycle pulses.
            instr_rvalid_reg <= 1'b0;
            data_rvalid_reg  <= 1'b0;
            instr_err_reg    <= 1'b0;
            data_err_reg     <= 1'b0;

            if (gnt[0]) begin
                addr_reg  <= instr_addr_i;
            end else if (gnt[1]) begin
                addr_reg  <= data_addr_i;
                be_reg    <= data_be_i;
                wdata_reg <= data_wdata_i;
            end

            if (state_reg == IDLE) begin
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
            end else begin
                if (aw_hs) aw_done_reg <= 1'b1;
                if (w_hs)  w_done_reg  <= 1'b1;
            end

            // Registering the response makes rvalid_o coincide with the
            // return to IDLE, so a new grant can overlap it.
            if (rready && m_axi.rvalid) begin
                if (owner == INSTR) begin
                    instr_rdata_reg  <= m_axi.rdata;
                    instr_rvalid_reg <= 1'b1;
                    instr_err_reg    <= resp_is_err(m_axi.rresp);
                end else begin
                    data_rdata_reg   <= m_axi.rdata;
                    data_rvalid_reg  <= 1'b1;
                    data_err_reg     <= resp_is_err(m_axi.rresp);
                end
            end

            // Only the data port ever writes; load data is left untouched.
            if (bready && m_axi.bvalid) begin
                data_rvalid_reg <= 1'b1;
                data_err_reg    <= resp_is_err(m_axi.bresp);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output drivers
    // -----------------------------------------------------------------------
    assign instr_rvalid_o = instr_rvalid_reg;
    assign instr_err_o    = instr_err_reg;
    assign instr_rdata_o  = instr_rdata_reg;
    assign data_rvalid_o  = data_rvalid_reg;
    assign data_err_o     = data_err_reg;
    assign data_rdata_o   = data_rdata_reg;

    assign m_axi.araddr   = addr_reg;
    assign m_axi.arprot   = (owner == INSTR) ? PROT_INSTR : PROT_DATA;
    assign m_axi.arvalid  = arvalid;
    assign m_axi.rready   = rready;
    assign m_axi.awaddr   = addr_reg;
    assign m_axi.awprot   = PROT_DATA;
    assign m_axi.awvalid  = awvalid;
    assign m_axi.wdata    = wdata_reg;
    assign m_axi.wstrb    = be_reg;
    assign m_axi.wvalid   = wvalid;
    assign m_axi.bready   = bready;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_mem_arbiter
//   Drives both core ports and plays the AXI4-Lite memory slave. A reference
//   model (round-robin winner, word memory, per-port held read data) predicts
//   grants, AXI payloads, response pulses and memory contents.
// ---------------------------------------------------------------------------
module tb_axi_mem_arbiter;

    logic        clk;
    logic        rst;

    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt, instr_rvalid, instr_err;
    logic [31:0] instr_rdata;

    logic        data_req, data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata;
    logic        data_gnt, data_rvalid, data_err;
    logic [31:0] data_rdata;

    axi_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_axi ();

    axi_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_err_o    (instr_err),
        .instr_rdata_o  (instr_rdata),
        .data_req_i     (data_req),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_addr_i    (data_addr),
        .data_wdata_i   (data_wdata),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_err_o     (data_err),
        .data_rdata_o   (data_rdata),
        .m_axi          (m_axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Slave-side memory (written from what the DUT puts on AW/W) and the
    // model's own memory (written from what the core asked for).
    logic [31:0] smem [32];
    logic [31:0] mmem [32];

    // Reference model state
    logic        m_last_data;      // 1: last grant went to data port
    logic [31:0] m_instr_rdata;
    logic [31:0] m_data_rdata;
    logic        last_winner_instr;

    // Slave behaviour for the next transaction
    int          cfg_ar_wait, cfg_r_wait, cfg_aw_wait, cfg_w_wait, cfg_b_wait;
    logic        cfg_err;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] w;
        w = 32'($urandom_range(0, 31));
        return w << 2;
    endfunction

    task automatic zero_waits();
        cfg_ar_wait = 0; cfg_r_wait = 0; cfg_aw_wait = 0;
        cfg_w_wait  = 0; cfg_b_wait = 0; cfg_err = 1'b0;
    endtask

    function automatic logic [1:0] err_resp(input logic e);
        if (!e) return 2'b00;
        return ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
    endfunction

    task automatic check_other_quiet(input logic owner_instr);
        if (owner_instr) begin
            check_eq("data_rvalid_quiet", data_rvalid, 1'b0);
            check_eq("data_rdata_held", data_rdata, m_data_rdata);
        end else begin
            check_eq("instr_rvalid_quiet", instr_rvalid, 1'b0);
            check_eq("instr_err_quiet", instr_err, 1'b0);
            check_eq("instr_rdata_held", instr_rdata, m_instr_rdata);
        end
    endtask

    // Called at a negedge with the DUT in IDLE and the request lines set.
    // Returns at the negedge of the cycle carrying the rvalid_o pulse.
    task automatic serve_txn();
        logic        win_instr, we;
        logic [31:0] a, wd, exp_rd, cap_awaddr, cap_wdata;
        logic [3:0]  be, cap_wstrb;
        int          n;
        #1;
        if (instr_req && data_req) win_instr = m_last_data;
        else                       win_instr = instr_req;
        check_eq("instr_gnt", instr_gnt, win_instr);
        check_eq("data_gnt", data_gnt, !win_instr);
        m_last_data       = !win_instr;
        last_winner_instr = win_instr;
        if (win_instr) begin
            a = instr_addr; we = 1'b0; be = 4'h0; wd = 32'h0;
        end else begin
            a = data_addr; we = data_we; be = data_be; wd = data_wdata;
        end
        @(posedge clk);
        @(negedge clk);
        if (win_instr) instr_req = 1'b0; else data_req = 1'b0;
        check_eq("busy_no_gnt", {30'b0, data_gnt, instr_gnt}, 32'h0);

        if (!we) begin
            check_eq("awvalid_on_read", m_axi.awvalid, 1'b0);
            check_eq("araddr", m_axi.araddr, a);
            check_eq("arprot", m_axi.arprot, win_instr ? 3'b100 : 3'b000);
            for (int k = 0; k <= cfg_ar_wait; k++) begin
                check_eq("arvalid", m_axi.arvalid, 1'b1);
                m_axi.arready = (k == cfg_ar_wait);
                @(negedge clk);
            end
            m_axi.arready = 1'b0;
            for (int k = 0; k <= cfg_r_wait; k++) begin
                check_eq("arvalid_dropped", m_axi.arvalid, 1'b0);
                check_eq("rready", m_axi.rready, 1'b1);
                check_eq("rvalid_early", {30'b0, data_rvalid, instr_rvalid}, 32'h0);
                if (k == cfg_r_wait) begin
                    m_axi.rvalid = 1'b1;
                    m_axi.rdata  = smem[a[6:2]];
                    m_axi.rresp  = err_resp(cfg_err);
                end
                @(negedge clk);
            end
            m_axi.rvalid = 1'b0;
            m_axi.rdata  = $urandom();
            exp_rd = mmem[a[6:2]];
            if (win_instr) begin
                m_instr_rdata = exp_rd;
                check_eq("instr_rvalid", instr_rvalid, 1'b1);
                check_eq("instr_err", instr_err, cfg_err);
                check_eq("instr_rdata", instr_rdata, exp_rd);
            end else begin
                m_data_rdata = exp_rd;
                check_eq("data_rvalid", data_rvalid, 1'b1);
                check_eq("data_err", data_err, cfg_err);
                check_eq("data_rdata", data_rdata, exp_rd);
            end
            check_eq("rready_after", m_axi.rready, 1'b0);
        end else begin
            check_eq("arvalid_on_write", m_axi.arvalid, 1'b0);
            check_eq("awaddr", m_axi.awaddr, a);
            check_eq("awprot", m_axi.awprot, 3'b000);
            check_eq("wdata", m_axi.wdata, wd);
            check_eq("wstrb", m_axi.wstrb, be);
            cap_awaddr = 32'h0; cap_wdata = 32'h0; cap_wstrb = 4'h0;
            n = (cfg_aw_wait > cfg_w_wait) ? cfg_aw_wait : cfg_w_wait;
            for (int k = 0; k <= n; k++) begin
                check_eq("awvalid", m_axi.awvalid, k <= cfg_aw_wait);
                check_eq("wvalid", m_axi.wvalid, k <= cfg_w_wait);
                check_eq("bready_early", m_axi.bready, 1'b0);
                m_axi.awready = (k == cfg_aw_wait);
                m_axi.wready  = (k == cfg_w_wait);
                if (k == cfg_aw_wait) cap_awaddr = m_axi.awaddr;
                if (k == cfg_w_wait) begin
                    cap_wdata = m_axi.wdata;
                    cap_wstrb = m_axi.wstrb;
                end
                @(negedge clk);
            end
            m_axi.awready = 1'b0;
            m_axi.wready  = 1'b0;
            for (int b = 0; b < 4; b++) begin
                if (cap_wstrb[b]) smem[cap_awaddr[6:2]][8*b +: 8] = cap_wdata[8*b +: 8];
                if (be[b])        mmem[a[6:2]][8*b +: 8]          = wd[8*b +: 8];
            end
            for (int k = 0; k <= cfg_b_wait; k++) begin
                check_eq("bready", m_axi.bready, 1'b1);
                check_eq("wr_valids_low", {30'b0, m_axi.awvalid, m_axi.wvalid}, 32'h0);
                check_eq("data_rvalid_early", data_rvalid, 1'b0);
                if (k == cfg_b_wait) begin
                    m_axi.bvalid = 1'b1;
                    m_axi.bresp  = err_resp(cfg_err);
                end
                @(negedge clk);
            end
            m_axi.bvalid = 1'b0;
            check_eq("wr_data_rvalid", data_rvalid, 1'b1);
            check_eq("wr_data_err", data_err, cfg_err);
            check_eq("wr_data_rdata_held", data_rdata, m_data_rdata);
            check_eq("mem_backdoor", smem[a[6:2]], mmem[a[6:2]]);
        end
        check_other_quiet(win_instr);
        n_txn++;
        $display("txn %0d: %s %s addr=0x%08h err=%0d", n_txn, win_instr ? "instr" : "data ",
                 we ? "write" : "read ", a, cfg_err);
    endtask

    task automatic raise_random_reqs();
        if (!instr_req && $urandom_range(0, 1) == 1) begin
            instr_req = 1'b1; instr_addr = rand_addr();
        end
        if (!data_req && $urandom_range(0, 1) == 1) begin
            data_req   = 1'b1;
            data_we    = ($urandom_range(0, 1) == 1);
            data_be    = 4'($urandom_range(1, 15));
            data_addr  = rand_addr();
            data_wdata = $urandom();
        end
        if (!instr_req && !data_req) begin
            instr_req = 1'b1; instr_addr = rand_addr();
        end
        cfg_ar_wait = $urandom_range(0, 3);
        cfg_r_wait  = $urandom_range(0, 3);
        cfg_aw_wait = $urandom_range(0, 3);
        cfg_w_wait  = $urandom_range(0, 3);
        cfg_b_wait  = $urandom_range(0, 3);
        cfg_err     = ($urandom_range(0, 3) == 0);
    endtask

    task automatic check_bus_idle(input string tag);
        check_eq(tag, {27'b0, m_axi.arvalid, m_axi.rready, m_axi.awvalid, m_axi.wvalid, m_axi.bready},
                 32'h0);
        check_eq({tag, "_pulses"}, {28'b0, instr_rvalid, instr_err, data_rvalid, data_err}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        instr_req = 1'b0; instr_addr = 32'h0;
        data_req = 1'b0; data_we = 1'b0; data_be = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
        m_axi.arready = 1'b0; m_axi.rvalid = 1'b0; m_axi.rdata = 32'h0; m_axi.rresp = 2'b00;
        m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.bvalid = 1'b0; m_axi.bresp = 2'b00;
        for (int i = 0; i < 32; i++) begin
            smem[i] = $urandom();
            mmem[i] = smem[i];
        end
        smem[0] = 32'h10000113;
        mmem[0] = 32'h10000113;
        m_last_data = 1'b1; m_instr_rdata = 32'h0; m_data_rdata = 32'h0;
        zero_waits();

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_bus_idle("reset_bus");
        check_eq("reset_gnt", {30'b0, data_gnt, instr_gnt}, 32'h0);
        check_eq("reset_araddr", m_axi.araddr, 32'h0);
        check_eq("reset_awaddr", m_axi.awaddr, 32'h0);
        check_eq("reset_wdata", m_axi.wdata, 32'h0);
        check_eq("reset_instr_rdata", instr_rdata, 32'h0);
        check_eq("reset_data_rdata", data_rdata, 32'h0);
        @(negedge clk);

        // Both ports requesting from reset: alternate starting with instr.
        instr_req = 1'b1; instr_addr = 32'h0000_0004;
        data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h0000_0008;
        for (int k = 0; k < 4; k++) begin
            serve_txn();
            check_eq("tie_order", last_winner_instr, (k % 2) == 0);
            instr_req = 1'b1;
            data_req  = 1'b1;
        end
        while (instr_req || data_req) serve_txn();

        // Instruction fetch from 0x0 with zero wait states.
        instr_req = 1'b1; instr_addr = 32'h0;
        serve_txn();

        // Full-word store to 0x70.
        data_req = 1'b1; data_we = 1'b1; data_be = 4'hF; data_addr = 32'h70; data_wdata = 32'hFF;
        serve_txn();
        check_eq("store_70_backdoor", smem[28], 32'h0000_00FF);

        // Store with awready delayed three cycles, wready immediate.
        cfg_aw_wait = 3;
        data_req = 1'b1; data_we = 1'b1; data_be = 4'b0101; data_addr = 32'h14; data_wdata = 32'hA5C3_5A3C;
        serve_txn();
        zero_waits();

        // Load answered with an error response.
        cfg_err = 1'b1;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h14;
        serve_txn();
        zero_waits();

        // Randomised traffic.
        for (int t = 0; t < 60; t++) begin
            raise_random_reqs();
            serve_txn();
        end
        zero_waits();
        while (instr_req || data_req) serve_txn();

        // Reset while a read is waiting for its data.
        instr_req = 1'b1; instr_addr = 32'h10;
        #1;
        check_eq("rst_test_gnt", instr_gnt, 1'b1);
        @(posedge clk);
        @(negedge clk);
        instr_req = 1'b0;
        m_axi.arready = 1'b1;
        @(negedge clk);
        m_axi.arready = 1'b0;
        check_eq("rst_test_rready", m_axi.rready, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_last_data = 1'b1; m_instr_rdata = 32'h0; m_data_rdata = 32'h0;
        check_bus_idle("post_rst_bus");
        check_eq("post_rst_instr_rdata", instr_rdata, 32'h0);
        repeat (2) begin
            @(negedge clk);
            check_bus_idle("post_rst_quiet");
        end
        instr_req = 1'b1; instr_addr = 32'h0;
        serve_txn();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_mem_arbiter.md
Name: axi_mem_arbiter

Overview:
Shares one AXI4-Lite master port between the core's instruction-fetch port (read-only) and data port (load/store). Both ports use the core's req/gnt/rvalid protocol. Sits between the core and the AXI interconnect/VIP slave, replacing the two separate instruction and data AXI paths. One transaction is outstanding at a time. Ties between the two ports are resolved round-robin.

Parameters:
ADDR_WIDTH, 32, address width of both core ports and AXI AR/AW
DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
instr_req_i / instr_addr_i  in  1 / ADDR_WIDTH  fetch request and address
instr_gnt_o / instr_rvalid_o / instr_err_o  out  1 each  grant, response-valid and error pulses
instr_rdata_o  out  DATA_WIDTH  fetched word
data_req_i / data_we_i / data_be_i  in  1 / 1 / DATA_WIDTH/8  load/store request, write enable, byte enables
data_addr_i / data_wdata_i  in  ADDR_WIDTH / DATA_WIDTH  data address and store data
data_gnt_o / data_rvalid_o / data_err_o  out  1 each  grant, response-valid and error pulses
data_rdata_o  out  DATA_WIDTH  load data
m_axi_araddr, m_axi_arprot[2:0], m_axi_arvalid  out; m_axi_arready  in  AR channel
m_axi_rdata, m_axi_rresp[1:0], m_axi_rvalid  in; m_axi_rready  out  R channel
m_axi_awaddr, m_axi_awprot[2:0], m_axi_awvalid  out; m_axi_awready  in  AW channel
m_axi_wdata, m_axi_wstrb, m_axi_wvalid  out; m_axi_wready  in  W channel
m_axi_bresp[1:0], m_axi_bvalid  in; m_axi_bready  out  B channel

Behaviour:
- Clocking: single clock domain. rst is synchronous and active-high.
- Reset values: all valid, ready, gnt, rvalid and err outputs are 0; addr, data and rdata outputs are 0; state = IDLE; rr_last = DATA, so the first tie goes to instr.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
- IDLE:
  - gnt is combinational and is asserted only in IDLE.
  - Exactly one gnt is high when at least one req is high.
  - Tie (both reqs high): grant the requester that is not rr_last.
  - On the edge where req&&gnt: latch addr/we/be/wdata and the owner; update rr_last.
  - Next state: RD_ADDR for instr, or for data with we=0; otherwise WR_ADDR.
- RD_ADDR:
  - arvalid=1, araddr = latched address.
  - arprot = 3'b100 for instr owner, 3'b000 for data owner.
  - On arvalid&&arready -> RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid&&rready: register rdata into the owner's rdata_o.
  - Next cycle: pulse the owner's rvalid_o; err_o = (rresp != OKAY), asserted in the same cycle as rvalid_o.
  - -> IDLE.
- WR_ADDR:
  - awvalid and wvalid are asserted together; wstrb = be; awprot = 3'b000.
  - Each valid drops independently after its own handshake; the address and data are never re-presented.
  - When both handshakes are done (same or different cycles) -> WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid: next cycle pulse data_rvalid_o; data_err_o = (bresp != OKAY); data_rdata_o unchanged.
  - -> IDLE.
- rvalid_o timing: rvalid_o is asserted in the same cycle the state returns to IDLE. A new gnt may therefore coincide with rvalid_o (back-to-back requests).
- rdata_o holds its value until the next read response for that port.
- Minimum latency: req/gnt at cycle 0, arvalid at cycle 1, rvalid_o at cycle 3 (slave with zero wait states).
- No request is dropped. A req held high while the other port owns the bus waits in IDLE arbitration until the state returns to IDLE.
- Instr writes do not exist; the instr port never drives AW/W.
- Reset mid-transaction: in the cycle after rst, all valids, readies and pulses are 0 and state is IDLE. The pending response is discarded, with no rvalid_o. The system resets the slave at the same time.
- Address is passed through unmodified; no alignment checks.

Decomposition:
- Package axi_mem_arbiter_pkg holds:
  - state enum
  - owner enum {INSTR, DATA}
  - AXI_RESP_OKAY = 2'b00
  - PROT_INSTR = 3'b100, PROT_DATA = 3'b000
- Sub-module rr_arbiter_2: two-requester round-robin.
  - Inputs: enable, req[1:0], clk, rst.
  - Outputs: one-hot gnt[1:0]; registered last pointer.
- The main module holds the FSM, the transaction latches and the AXI drivers.

Test Plan:
- Instr only, addr 0x0, slave holds 0x10000113, zero wait states -> instr_gnt at cycle 0, araddr=0x0 arprot=3'b100 at cycle 1, instr_rvalid_o with rdata 0x10000113 at cycle 3, err=0.
- Data store, addr 0x70, wdata 0x000000FF, be 4'b1111 -> awaddr=0x70, wdata=0xFF, wstrb=4'hF, awprot=0; B OKAY -> one data_rvalid_o pulse; backdoor read of 0x70 returns 0xFF.
- Both reqs high from reset, four times in a row -> grants ordered instr, data, instr, data; each rvalid_o goes to the correct port.
- Store with awready delayed 3 cycles, wready=1 -> wvalid high for 1 cycle only; awvalid high for 4 cycles; bready asserted only after both handshakes.
- Data load with rresp=SLVERR -> data_rvalid_o and data_err_o pulse together; instr_* outputs unaffected.
- rst pulsed for 1 cycle while in RD_DATA -> next cycle all AXI valids/readies = 0, no rvalid_o; a new instr req is granted normally afterwards.
